// File: rtl/ldm_writeback_sequencer.sv
// ldm_writeback_sequencer
//   Drives the write port of a 16x32 register file to carry out an ARM
//   load-multiple (increment-after). One memory word is fetched for each set
//   bit of the register list, lowest index first. Each word is then written
//   to the register file as an I/Rc/LE triple.
//
//   Optional feature macro: WRITEBACK_BASE_EN
//     When defined, a one-cycle WB state follows the last load. It writes
//     base_addr + ADDR_STEP*count back to base_reg. No write occurs if
//     base_reg was part of the loaded list.
//     When undefined, base_reg is ignored.
//
//   Ports
//     clk        clock, rising edge
//     clr        asynchronous reset, active-low
//     start      one-cycle request, accepted only when idle
//     reg_list   registers to load (bit n -> Rn), sampled with start
//     base_addr  first memory address, sampled with start
//     base_reg   base register index, sampled with start
//     mem_req    memory read request
//     mem_addr   address of the current read
//     mem_ack    read data valid (meaningful only while mem_req=1)
//     mem_rdata  read data
//     I, Rc, LE  register file write data / index / enable
//     busy       transfer in progress
//     done       one-cycle completion pulse
module ldm_writeback_sequencer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] I,
    output logic [3:0]        Rc,
    output logic              LE,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WRITE = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       list_q, list_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        count_q, count_d;
    logic [DATA_W-1:0] I_q, I_d;
    logic [3:0]        Rc_q, Rc_d;
    logic [15:0]       list_rem;

`ifdef WRITEBACK_BASE_EN
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic [15:0]       orig_q, orig_d;
`else
    logic              unused_base_reg;
    assign unused_base_reg = ^base_reg;
`endif

    function automatic logic [3:0] lowest_idx(input logic [15:0] l);
        logic [3:0] idx;
        idx = '0;
        for (int n = 15; n >= 0; n--) begin
            if (l[n]) idx = 4'(n);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit retires the register just written.
    assign list_rem = list_q & (list_q - 16'd1);

    // State and datapath registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            list_q     <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            I_q        <= '0;
            Rc_q       <= '0;
`ifdef WRITEBACK_BASE_EN
            base_q     <= '0;
            base_reg_q <= '0;
            orig_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            I_q        <= I_d;
            Rc_q       <= Rc_d;
`ifdef WRITEBACK_BASE_EN
            base_q     <= base_d;
            base_reg_q <= base_reg_d;
            orig_q     <= orig_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (reg_list != 16'd0) ? S_REQ : S_DONE;
            S_REQ:   if (mem_ack) state_d = S_WRITE;
            S_WRITE: begin
                if (list_rem != 16'd0) begin
                    state_d = S_REQ;
                end else begin
`ifdef WRITEBACK_BASE_EN
                    state_d = S_WB;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        list_d     = list_q;
        addr_d     = addr_q;
        count_d    = count_q;
        I_d        = I_q;
        Rc_d       = Rc_q;
`ifdef WRITEBACK_BASE_EN
        base_d     = base_q;
        base_reg_d = base_reg_q;
        orig_d     = orig_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    list_d     = reg_list;
                    addr_d     = base_addr;
                    count_d    = '0;
`ifdef WRITEBACK_BASE_EN
                    base_d     = base_addr;
                    base_reg_d = base_reg;
                    orig_d     = reg_list;
`endif
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    I_d  = mem_rdata;
                    Rc_d = lowest_idx(list_q);
                end
            end
            S_WRITE: begin
                list_d  = list_rem;
                addr_d  = addr_q + ADDR_W'(ADDR_STEP);
                count_d = count_q + 5'd1;
`ifdef WRITEBACK_BASE_EN
                // Preload the writeback triple so it is presented during WB.
                // A base register that was itself loaded keeps its loaded value.
                if ((list_rem == 16'd0) && !orig_q[base_reg_q]) begin
                    I_d  = DATA_W'(base_q + ADDR_W'(ADDR_STEP) * ADDR_W'(count_d));
                    Rc_d = base_reg_q;
                end
`endif
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state, so reset cannot glitch LE
    always_comb begin
        mem_req  = (state_q == S_REQ);
        mem_addr = addr_q;
        I        = I_q;
        Rc       = Rc_q;
        busy     = (state_q == S_REQ) || (state_q == S_WRITE) || (state_q == S_WB);
        done     = (state_q == S_DONE);
        LE       = (state_q == S_WRITE);
`ifdef WRITEBACK_BASE_EN
        if (state_q == S_WB) LE = !orig_q[base_reg_q];
`endif
    end

endmodule

// File: tb/tb_ldm_writeback_sequencer.sv
module tb_ldm_writeback_sequencer;

    logic        clk;
    logic        clr;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic [3:0]  base_reg;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] I;
    logic [3:0]  Rc;
    logic        LE;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    int          n_le, n_req, done_at;
    logic [3:0]  le_rc  [32];
    logic [31:0] le_i   [32];
    int          le_cyc [32];
    logic [31:0] req_addr [32];

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    ldm_writeback_sequencer #(.DATA_W(32), .ADDR_W(32), .ADDR_STEP(4)) dut (
        .clk(clk), .clr(clr), .start(start), .reg_list(reg_list),
        .base_addr(base_addr), .base_reg(base_reg), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .I(I), .Rc(Rc), .LE(LE), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] l, input logic [31:0] b, input logic [3:0] br);
        start = 1'b1; reg_list = l; base_addr = b; base_reg = br;
        step();
        start = 1'b0;
    endtask

    // Memory always acknowledges; data is the address XOR KEY. Records every
    // REQ address and LE write until done or the cycle budget runs out.
    task automatic run_ack(input int maxc);
        n_le = 0; n_req = 0; done_at = -1;
        for (int c = 0; c < maxc; c++) begin
            if (mem_req && n_req < 32) begin req_addr[n_req] = mem_addr; n_req++; end
            if (LE && n_le < 32) begin
                le_rc[n_le] = Rc; le_i[n_le] = I; le_cyc[n_le] = c; n_le++;
            end
            if (done) begin done_at = c; break; end
            mem_ack = 1'b1;
            mem_rdata = mem_addr ^ KEY;
            step();
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        step(); step();
        checks++;
        if ({mem_req, mem_addr, I, Rc, LE, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs actual=%h required=0",
                     {mem_req, mem_addr, I, Rc, LE, busy, done});
        end
        clr = 1'b1;
        step();
        issue(16'h0001, 32'h0000_0300, 4'd0);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            errors++;
            $display("FAIL reset_pre_req actual=%b/%h required=1/00000300", mem_req, mem_addr);
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, I, Rc, LE, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_midtransfer actual=%h required=0",
                     {mem_req, mem_addr, I, Rc, LE, busy, done});
        end
        step();
        clr = 1'b1;
        step();
        issue(16'h0002, 32'h0000_0020, 4'd0);
        run_ack(10);
        checks++;
        if (n_le !== 1 || le_rc[0] !== 4'd1 || le_i[0] !== (32'h20 ^ KEY) || done_at !== 2) begin
            errors++;
            $display("FAIL reset_after_release actual=n%0d rc%0d i%h d%0d required=n1 rc1 i%h d2",
                     n_le, le_rc[0], le_i[0], done_at, 32'h20 ^ KEY);
        end
        step();
    endtask

    task automatic test_two_regs();
        issue(16'h0005, 32'h0000_0100, 4'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL two_busy actual=%b required=1", busy);
        end
        run_ack(20);
        checks++;
        if (n_req !== 2 || req_addr[0] !== 32'h100 || req_addr[1] !== 32'h104) begin
            errors++;
            $display("FAIL two_addr actual=n%0d %h %h required=n2 00000100 00000104",
                     n_req, req_addr[0], req_addr[1]);
        end
        checks++;
        if (n_le !== 2 || le_rc[0] !== 4'd0 || le_rc[1] !== 4'd2 ||
            le_i[0] !== (32'h100 ^ KEY) || le_i[1] !== (32'h104 ^ KEY)) begin
            errors++;
            $display("FAIL two_writes actual=n%0d R%0d=%h R%0d=%h required=n2 R0=%h R2=%h",
                     n_le, le_rc[0], le_i[0], le_rc[1], le_i[1], 32'h100 ^ KEY, 32'h104 ^ KEY);
        end
        checks++;
        if (le_cyc[1] - le_cyc[0] !== 2 || done_at !== le_cyc[1] + 1) begin
            errors++;
            $display("FAIL two_timing actual=le%0d,%0d done%0d required=le 2 apart done next",
                     le_cyc[0], le_cyc[1], done_at);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL two_done_busy actual=%b required=0", busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL two_idle actual=%b%b required=00", done, busy);
        end
    endtask

    task automatic test_wait_states();
        int reqs, les, dseen;
        logic [3:0] rc_seen;
        reqs = 0; les = 0; dseen = 0; rc_seen = 4'd0;
        issue(16'h8000, 32'h0000_0040, 4'd0);
        for (int c = 0; c < 12; c++) begin
            if (mem_req) reqs++;
            if (LE) begin les++; rc_seen = Rc; end
            if (done) begin dseen = 1; break; end
            mem_ack = (c == 3);
            mem_rdata = 32'hCAFE_0015;
            step();
        end
        mem_ack = 1'b0;
        checks++;
        if (reqs !== 4) begin
            errors++; $display("FAIL wait_req_cycles actual=%0d required=4", reqs);
        end
        checks++;
        if (les !== 1 || rc_seen !== 4'd15 || I !== 32'hCAFE_0015 || dseen !== 1) begin
            errors++;
            $display("FAIL wait_write actual=le%0d rc%0d i%h d%0d required=le1 rc15 iCAFE0015 d1",
                     les, rc_seen, I, dseen);
        end
        step();
    endtask

    task automatic test_empty_list();
        issue(16'h0000, 32'h0000_0500, 4'd0);
        checks++;
        if (done !== 1'b1 || mem_req !== 1'b0 || LE !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done actual=d%b r%b le%b b%b required=d1 r0 le0 b0",
                     done, mem_req, LE, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || mem_req !== 1'b0 || LE !== 1'b0) begin
            errors++; $display("FAIL empty_after actual=d%b r%b le%b required=000", done, mem_req, LE);
        end
    endtask

    task automatic test_ignore_start_wrap();
        issue(16'h0003, 32'hFFFF_FFFC, 4'd0);
        checks++;
        if (mem_addr !== 32'hFFFF_FFFC || mem_req !== 1'b1) begin
            errors++; $display("FAIL wrap_first_addr actual=%h required=fffffffc", mem_addr);
        end
        // Second start arrives while busy and must be ignored.
        start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h0000_0500;
        mem_ack = 1'b1; mem_rdata = mem_addr ^ KEY;
        step();
        start = 1'b0; mem_ack = 1'b0;
        run_ack(20);
        checks++;
        if (n_req !== 1 || req_addr[0] !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap_second_addr actual=n%0d %h required=n1 00000000", n_req, req_addr[0]);
        end
        checks++;
        if (n_le !== 2 || le_rc[0] !== 4'd0 || le_rc[1] !== 4'd1 ||
            le_i[0] !== (32'hFFFF_FFFC ^ KEY) || le_i[1] !== KEY || done_at !== 3) begin
            errors++;
            $display("FAIL ignore_start actual=n%0d rc%0d,%0d i%h,%h d%0d required=n2 rc0,1 d3",
                     n_le, le_rc[0], le_rc[1], le_i[0], le_i[1], done_at);
        end
        step();
    endtask

`ifdef WRITEBACK_BASE_EN
    task automatic test_writeback();
        issue(16'h000F, 32'h0000_0200, 4'd13);
        run_ack(30);
        checks++;
        if (n_le !== 5 || le_rc[4] !== 4'd13 || le_i[4] !== 32'h0000_0210 || done_at !== 9) begin
            errors++;
            $display("FAIL wb_base actual=n%0d R%0d=%h d%0d required=n5 R13=00000210 d9",
                     n_le, le_rc[4], le_i[4], done_at);
        end
        step();
        issue(16'h2001, 32'h0000_0200, 4'd13);
        run_ack(30);
        checks++;
        if (n_le !== 2 || le_rc[1] !== 4'd13 || le_i[1] !== (32'h204 ^ KEY) || done_at !== 5) begin
            errors++;
            $display("FAIL wb_in_list actual=n%0d R%0d=%h d%0d required=n2 R13=%h d5",
                     n_le, le_rc[1], le_i[1], done_at, 32'h204 ^ KEY);
        end
        step();
    endtask
`else
    task automatic test_no_writeback();
        issue(16'h000F, 32'h0000_0200, 4'd13);
        run_ack(30);
        checks++;
        if (n_le !== 4 || le_rc[3] !== 4'd3 || le_i[3] !== (32'h20C ^ KEY) || done_at !== 8) begin
            errors++;
            $display("FAIL no_wb actual=n%0d R%0d=%h d%0d required=n4 R3=%h d8",
                     n_le, le_rc[3], le_i[3], done_at, 32'h20C ^ KEY);
        end
        step();
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        start = 1'b0; reg_list = '0; base_addr = '0; base_reg = '0;
        mem_ack = 1'b0; mem_rdata = '0; clr = 1'b0;
        test_reset();
        test_two_regs();
        test_wait_states();
        test_empty_list();
        test_ignore_start_wrap();
`ifdef WRITEBACK_BASE_EN
        test_writeback();
`else
        test_no_writeback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
